scp_tile_fetch: RTL
===================

# scp_tile_fetch

Parametrised, time-slotted VRAM fetch sequencer for the Taito tilemap generators. It serves 1–4 scrolling BG layers and CPU access from one synchronous 16-bit VRAM. At each line start it optionally fetches per-layer row-scroll words. It then runs a fixed repeating slot schedule that fetches the attribute and code words for every layer, once per 8-pixel tile group. It sits between the CPU bus glue, the VRAM, and the per-layer pixel shifters.

## Interface
Parameters:
- LAYERS, 4: number of BG layers, 1..4.
- ADDR_W, 16: VRAM word-address width.
- MAP_AW, 13: log2 words per layer tilemap. Layer l base = l<<MAP_AW.
- ROWSCROLL_BASE, 16'h8000: word base of the row-scroll tables. Layer l line y is at ROWSCROLL_BASE + l*512 + y.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ce  in  1  slot enable. All state advances only when ce=1.
- line_start  in  1  line strobe, sampled on ce.
- frame_start  in  1  frame strobe, sampled on ce.
- xscroll  in  16*LAYERS  per-layer X scroll. Only [8:0] is used.
- yscroll  in  16*LAYERS  per-layer Y scroll. Only [8:0] is used.
- cpu_req  in  1  CPU request. Held high until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_be  in  2  byte enables, {hi, lo}.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data, valid with cpu_ack.
- cpu_ack  out  1  one-clk completion pulse.
- ram_addr  out  ADDR_W  VRAM address.
- ram_wdata  out  16  VRAM write data.
- ram_we  out  2  byte write strobes, active-high.
- ram_rdata  in  16  VRAM read data. Valid one ce-cycle after address.
- tile_attr  out  16*LAYERS  committed attribute words.
- tile_code  out  16*LAYERS  committed code words.
- tile_strobe  out  1  one-clk pulse when new tile data is committed.
- tile_index  out  6  tile column of the committed data.
- line_y  out  9  current line counter.

## Operation
- States: IDLE, HEAD, GROUP.
- Reset sends the FSM to IDLE and clears every output, line_y, tile counter, the internal row-scroll registers and the CPU pending flag.
- IDLE/any state + line_start → HEAD, slot 0. line_y increments by 1, mod 512. If frame_start is also active, line_y = 0 (frame_start wins). frame_start alone clears line_y and does not change state.
- HEAD: LAYERS slots. Slot l addresses ROWSCROLL_BASE + l*512 + line_y. The data is captured into rowscroll[l] on the following ce. After the last slot → GROUP, slot 0, tile counter 0.
- GROUP: G = 2*LAYERS + 2 slots.
  - Slot 0: CPU_A.
  - Slots 2l+1 and 2l+2: layer l attribute and code fetch.
  - Slot G−1: CPU_B.
  - After slot G−1, the FSM loops to slot 0 and the tile counter increments mod 64. It runs until the next line_start.
- Layer address arithmetic, all 9-bit with wrap:
  - x = {tile,3'b0} + xscroll[l] + rowscroll[l].
  - y = line_y + yscroll[l].
  - Attribute address = (l<<MAP_AW) + {y[8:3], x[8:3], 1'b0}.
  - Code address = attribute address | 1.
- Fetched words go to staging registers. At the ce following slot G−1, all staging registers copy to tile_attr/tile_code together, tile_index = tile counter, and tile_strobe pulses.
- CPU handling:
  - A rising edge of cpu_req sets pending and latches we/be/addr/wdata.
  - The next CPU_A or CPU_B slot with pending set drives cpu_addr.
  - For a write, ram_we = cpu_be and ram_wdata = cpu_wdata.
  - On the following ce, cpu_rdata = ram_rdata (reads only), cpu_ack pulses, and pending clears.
  - cpu_req held high after ack does not re-trigger.
- Non-CPU slots and CPU slots without pending: ram_we = 0.
- line_start mid-group aborts the group without committing, and the tile counter resets. A pending CPU request survives and is served at the first CPU slot after HEAD.

## Timing
- Read latency: address at ce n, data captured at ce n+1.
- Slot 0 data is captured during slot 1, so the pipeline never stalls.
- Commit occurs one ce after slot G−1, concurrent with the next group's slot 0.
- Worst-case CPU latency: LAYERS + 2*LAYERS + 2 ce cycles, i.e. HEAD plus one group span.
- ram_addr/ram_we are registered. They change only on ce and are stable between ce pulses.

## Configuration
- SCP_ROWSCROLL_EN defined: HEAD performs the row-scroll fetches described above.
- Undefined: HEAD still lasts LAYERS slots so the schedule is unchanged. These slots drive ram_addr = 0 with no write and are not captured. rowscroll[l] is constant 0.

## Test plan
- Reset, then LAYERS=4, all scrolls 0, line_start with line_y→1 → HEAD, then slot 1 ram_addr=0x0000, slot 2 0x0001, slot 3 0x2000. One ce after slot 9: tile_strobe=1, tile_index=0.
- xscroll1=16, line_y=0 (frame_start+line_start) → layer 1 tile 0 attribute address 0x2004, code address 0x2005.
- SCP_ROWSCROLL_EN, line_y=3, VRAM[0x8003]=8 → HEAD slot 0 ram_addr=0x8003. Layer 0 tile 0 attribute address 0x0002.
- CPU write cpu_addr=0x1234, be=2'b01, data=0xABCD during group slot 3 → ram_we=2'b01 in CPU_B slot 9. cpu_ack one ce later. A subsequent read returns 0x??CD.
- line_start asserted mid-group at slot 5 → no tile_strobe. The next HEAD starts, and the tile counter restarts at 0.
- Reset asserted with a CPU request pending → no cpu_ack, all outputs 0, FSM IDLE until line_start.

Source files
------------

// File: rtl/scp_tile_fetch.sv
// scp_tile_fetch: time-slotted VRAM fetch sequencer serving 1-4 BG layers plus CPU access.
// Define SCP_ROWSCROLL_EN to fetch per-layer row-scroll words during HEAD.
module scp_tile_fetch #(
  parameter int LAYERS = 4,
  parameter int ADDR_W = 16,
  parameter int MAP_AW = 13,
  parameter logic [ADDR_W-1:0] ROWSCROLL_BASE = 16'h8000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   line_start,
  input  logic                   frame_start,
  input  logic [16*LAYERS-1:0]   xscroll,
  input  logic [16*LAYERS-1:0]   yscroll,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [1:0]             cpu_be,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [15:0]            cpu_wdata,
  output logic [15:0]            cpu_rdata,
  output logic                   cpu_ack,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [15:0]            ram_wdata,
  output logic [1:0]             ram_we,
  input  logic [15:0]            ram_rdata,
  output logic [16*LAYERS-1:0]   tile_attr,
  output logic [16*LAYERS-1:0]   tile_code,
  output logic                   tile_strobe,
  output logic [5:0]             tile_index,
  output logic [8:0]             line_y
);
  localparam logic [3:0] HL = 4'(LAYERS - 1);
  localparam logic [3:0] GL = 4'(2 * LAYERS + 1);
  typedef enum logic [1:0] {IDLE, HEAD, GROUP} state_t;
  state_t state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [5:0] tile_q, tile_d;
  logic [8:0] line_y_d;
  logic [LAYERS-1:0][8:0] rowscroll_q;
  logic [LAYERS-1:0][15:0] attr_q, code_q;
  logic req_q, rise, pend_q, pend_d, serve_q, serve_d, cwe_q, cwe_d;
  logic [1:0] cbe_q, cbe_d, we_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d, addr_d, a;
  logic [15:0] cwdata_q, cwdata_d, wdata_d;
  logic unused_ok;
  assign unused_ok = ^{xscroll, yscroll, ROWSCROLL_BASE};

  function automatic logic [ADDR_W-1:0] map_addr(input int l, input logic [8:0] x, input logic [8:0] y);
    return (ADDR_W'(l) << MAP_AW) + ADDR_W'({y[8:3], x[8:3], 1'b0});
  endfunction

  always_comb begin
    rise = cpu_req & ~req_q;
    pend_d = (pend_q & ~serve_q) | rise;
    cwe_d = rise ? cpu_we : cwe_q;
    cbe_d = rise ? cpu_be : cbe_q;
    caddr_d = rise ? cpu_addr : caddr_q;
    cwdata_d = rise ? cpu_wdata : cwdata_q;
    state_d = state_q;
    slot_d = slot_q;
    tile_d = tile_q;
    line_y_d = frame_start ? 9'd0 : line_y;
    if (line_start) begin
      state_d = HEAD;
      slot_d = '0;
      tile_d = '0;
      line_y_d = frame_start ? 9'd0 : line_y + 9'd1;
    end else if (state_q == HEAD) begin
      state_d = slot_q == HL ? GROUP : HEAD;
      slot_d = slot_q == HL ? 4'd0 : slot_q + 4'd1;
    end else if (state_q == GROUP) begin
      slot_d = slot_q == GL ? 4'd0 : slot_q + 4'd1;
      tile_d = slot_q == GL ? tile_q + 6'd1 : tile_q;
    end
    // the address registered now belongs to the slot being entered
    serve_d = pend_d && state_d == GROUP && (slot_d == 4'd0 || slot_d == GL);
    addr_d = serve_d ? caddr_d : '0;
    we_d = serve_d && cwe_d ? cbe_d : 2'b00;
    wdata_d = serve_d && cwe_d ? cwdata_d : 16'h0;
`ifdef SCP_ROWSCROLL_EN
    if (state_d == HEAD) addr_d = ROWSCROLL_BASE + ADDR_W'({slot_d, 9'h0}) + ADDR_W'(line_y_d);
`endif
    a = '0;
    for (int l = 0; l < LAYERS; l++) begin
      a = map_addr(l, {tile_d, 3'b000} + xscroll[16*l +: 9] + rowscroll_q[l], line_y_d + yscroll[16*l +: 9]);
      if (state_d == GROUP && slot_d == 4'(2*l+1)) addr_d = a;
      if (state_d == GROUP && slot_d == 4'(2*l+2)) addr_d = {a[ADDR_W-1:1], 1'b1};
    end
  end

`ifdef SCP_ROWSCROLL_EN
  always_ff @(posedge clk) begin
    if (reset) rowscroll_q <= '0;
    else if (ce && state_q == HEAD)
      for (int l = 0; l < LAYERS; l++)
        if (slot_q == 4'(l)) rowscroll_q[l] <= ram_rdata[8:0];
  end
`else
  assign rowscroll_q = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q <= '0;
      tile_q <= '0;
      line_y <= '0;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      serve_q <= 1'b0;
      cwe_q <= 1'b0;
      cbe_q <= '0;
      caddr_q <= '0;
      cwdata_q <= '0;
      attr_q <= '0;
      code_q <= '0;
      ram_addr <= '0;
      ram_we <= '0;
      ram_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ack <= 1'b0;
      tile_attr <= '0;
      tile_code <= '0;
      tile_strobe <= 1'b0;
      tile_index <= '0;
    end else begin
      cpu_ack <= 1'b0;
      tile_strobe <= 1'b0;
      if (ce) begin
        state_q <= state_d;
        slot_q <= slot_d;
        tile_q <= tile_d;
        line_y <= line_y_d;
        req_q <= cpu_req;
        pend_q <= pend_d;
        serve_q <= serve_d;
        cwe_q <= cwe_d;
        cbe_q <= cbe_d;
        caddr_q <= caddr_d;
        cwdata_q <= cwdata_d;
        ram_addr <= addr_d;
        ram_we <= we_d;
        ram_wdata <= wdata_d;
        if (serve_q) begin
          cpu_ack <= 1'b1;
          cpu_rdata <= cwe_q ? cpu_rdata : ram_rdata;
        end
        for (int l = 0; l < LAYERS; l++) begin
          if (state_q == GROUP && slot_q == 4'(2*l+1)) attr_q[l] <= ram_rdata;
          if (state_q == GROUP && slot_q == 4'(2*l+2)) code_q[l] <= ram_rdata;
        end
        // a line_start landing on the last slot still aborts the group
        if (state_q == GROUP && slot_q == GL && !line_start) begin
          tile_attr <= attr_q;
          tile_code <= code_q;
          tile_index <= tile_q;
          tile_strobe <= 1'b1;
        end
      end
    end
  end
endmodule
